// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter.
// Register address width, word geometry and grant sources.
package rf_write_arbiter_pkg;

   localparam int REG_AW         = 3;
   localparam int RF_DEPTH       = 1 << REG_AW;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic {
      IDLE,
      WRITE
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_PIPE,
      GNT_MAT
   } gnt_e;

   // Destination set of a word: four consecutive registers, wrapping.
   function automatic logic [RF_DEPTH-1:0] word_mask(
      input logic [REG_AW-1:0] base
   );
      logic [RF_DEPTH-1:0] m;
      m = '0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         m[base + REG_AW'(k)] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_starve.sv
// Starvation guard for pending matrix bytes.
// Counts lost arbitrations and raises a registered pipeline stall.
module rf_starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pending,
   input  logic lost,
   input  logic won,
   output logic stall
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   // Saturating loss count, cleared by a matrix win or when idle.
   always_comb begin
      cnt_nxt = cnt;
      if (!pending || won) begin
         cnt_nxt = '0;
      end else if (lost && cnt != LIMIT) begin
         cnt_nxt = cnt + 4'd1;
      end
   end

   // Stall is held from the edge the limit is hit until the next win.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         stall <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         stall <= (cnt_nxt == LIMIT);
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port owner: pipeline writeback vs matrix bytes.
// A 32-bit matrix word is written as four bytes to consecutive registers.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_REGS     = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                mat_valid,
   output logic                mat_ready,
   input  logic [31:0]         mat_data,
   input  logic [REG_AW-1:0]   mat_base,
   input  logic                pipe_we,
   input  logic [REG_AW-1:0]   pipe_waddr,
   input  logic [7:0]          pipe_wdata,
   output logic                pipe_stall,
   output logic                rf_we,
   output logic [REG_AW-1:0]   rf_waddr,
   output logic [7:0]          rf_wdata,
   output logic                busy,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic                mat_done
);

   state_e            state;
   gnt_e              gnt;
   logic [31:0]       word;
   logic [REG_AW-1:0] base;
   logic [1:0]        idx;
   logic [REG_AW-1:0] mat_addr;
   logic [7:0]        mat_byte;
   logic              take;
   logic              last;
   logic              in_write;

   assign in_write  = (state == WRITE);
   assign mat_ready = (state == IDLE);
   assign take      = mat_valid && mat_ready;
   assign mat_addr  = base + REG_AW'(idx);
   assign mat_byte  = word[{idx, 3'b000} +: 8];
   assign last      = (idx == 2'(BYTES_PER_WORD - 1));

   // Pipeline wins unless stalled; otherwise the matrix byte goes.
   always_comb begin
      gnt = GNT_NONE;
      if (in_write) begin
         gnt = (pipe_we && !pipe_stall) ? GNT_PIPE : GNT_MAT;
      end else if (pipe_we) begin
         gnt = GNT_PIPE;
      end
   end

   rf_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .reset_n (reset_n),
      .pending (in_write),
      .lost    (in_write && gnt == GNT_PIPE),
      .won     (gnt == GNT_MAT),
      .stall   (pipe_stall)
   );

   // Word capture, byte sequencing, pending set and completion pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         word         <= '0;
         base         <= '0;
         idx          <= '0;
         busy         <= 1'b0;
         pending_mask <= '0;
         mat_done     <= 1'b0;
      end else begin
         mat_done <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  word         <= mat_data;
                  base         <= mat_base;
                  idx          <= '0;
                  busy         <= 1'b1;
                  pending_mask <= NUM_REGS'(word_mask(mat_base));
                  state        <= WRITE;
               end
            end
            WRITE: begin
               if (gnt == GNT_MAT) begin
                  pending_mask[mat_addr] <= 1'b0;
                  idx <= idx + 2'd1;
                  if (last) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     mat_done <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Registered write port; address and data hold when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= 1'b0;
         unique case (gnt)
            GNT_PIPE: begin
               rf_we    <= 1'b1;
               rf_waddr <= pipe_waddr;
               rf_wdata <= pipe_wdata;
            end
            GNT_MAT: begin
               rf_we    <= 1'b1;
               rf_waddr <= mat_addr;
               rf_wdata <= mat_byte;
            end
            default: rf_we <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter.
// Expected writes are queued at stimulus time and popped on rf_we.
module tb_rf_write_arbiter;

   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
      logic       done;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic        mat_valid;
   logic        mat_ready;
   logic [31:0] mat_data;
   logic [2:0]  mat_base;
   logic        pipe_we;
   logic [2:0]  pipe_waddr;
   logic [7:0]  pipe_wdata;
   logic        pipe_stall;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic        busy;
   logic [7:0]  pending_mask;
   logic        mat_done;

   int  n_cmp;
   int  n_err;
   wr_t sb[$];
   wr_t e;

   rf_write_arbiter #(
      .STARVE_LIMIT (4),
      .NUM_REGS     (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mat_valid    (mat_valid),
      .mat_ready    (mat_ready),
      .mat_data     (mat_data),
      .mat_base     (mat_base),
      .pipe_we      (pipe_we),
      .pipe_waddr   (pipe_waddr),
      .pipe_wdata   (pipe_wdata),
      .pipe_stall   (pipe_stall),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .busy         (busy),
      .pending_mask (pending_mask),
      .mat_done     (mat_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] a, input logic [7:0] d,
                       input logic dn);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.done = dn;
      sb.push_back(w);
   endtask

   task automatic push_word(input logic [2:0] b, input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         push(b + 3'(k), w[8*k +: 8], k == 3);
      end
   endtask

   task automatic offer(input logic [2:0] b, input logic [31:0] w);
      mat_valid = 1'b1;
      mat_base  = b;
      mat_data  = w;
   endtask

   // Every write-port transfer is checked against the queue head.
   always @(posedge clk) begin
      #1;
      if (rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 32'(rf_we), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
            chk("mat_done_w", 32'(mat_done), 32'(e.done));
         end
      end else begin
         chk("mat_done_idle", 32'(mat_done), 32'd0);
      end
   end

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      mat_valid  = 1'b0;
      mat_data   = '0;
      mat_base   = '0;
      pipe_we    = 1'b0;
      pipe_waddr = '0;
      pipe_wdata = '0;

      // reset state
      tick();
      tick();
      chk("rst_we", 32'(rf_we), 0);
      chk("rst_addr", 32'(rf_waddr), 0);
      chk("rst_data", 32'(rf_wdata), 0);
      chk("rst_stall", 32'(pipe_stall), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mask", 32'(pending_mask), 0);
      chk("rst_done", 32'(mat_done), 0);
      reset_n = 1'b1;
      tick();
      chk("rst_ready", 32'(mat_ready), 1);

      // uncontended word, base 0
      offer(3'd0, 32'hDDCC_BBAA);
      push_word(3'd0, 32'hDDCC_BBAA);
      tick();
      mat_valid = 1'b0;
      chk("t1_mask0", 32'(pending_mask), 32'h0F);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready", 32'(mat_ready), 0);
      tick();
      chk("t1_mask1", 32'(pending_mask), 32'h0E);
      tick();
      chk("t1_mask2", 32'(pending_mask), 32'h0C);
      tick();
      chk("t1_mask3", 32'(pending_mask), 32'h08);
      tick();
      chk("t1_mask4", 32'(pending_mask), 32'h00);
      chk("t1_done", 32'(mat_done), 1);
      chk("t1_idle", 32'(busy), 0);
      chk("t1_ready2", 32'(mat_ready), 1);

      // wrap-around, base 6
      offer(3'd6, 32'h4433_2211);
      push_word(3'd6, 32'h4433_2211);
      tick();
      mat_valid = 1'b0;
      chk("t2_mask", 32'(pending_mask), 32'hC3);
      repeat (4) tick();
      chk("t2_mask_end", 32'(pending_mask), 0);

      // pipeline priority for two cycles, R5 also pending
      offer(3'd2, 32'h8899_AABB);
      push(3'd5, 8'h7E, 1'b0);
      push(3'd5, 8'h7E, 1'b0);
      push_word(3'd2, 32'h8899_AABB);
      tick();
      mat_valid  = 1'b0;
      pipe_we    = 1'b1;
      pipe_waddr = 3'd5;
      pipe_wdata = 8'h7E;
      tick();
      chk("t3_stall1", 32'(pipe_stall), 0);
      chk("t3_mask1", 32'(pending_mask), 32'h3C);
      tick();
      chk("t3_stall2", 32'(pipe_stall), 0);
      chk("t3_mask2", 32'(pending_mask), 32'h3C);
      pipe_we = 1'b0;
      repeat (4) begin
         tick();
         chk("t3_stall_m", 32'(pipe_stall), 0);
      end
      chk("t3_busy", 32'(busy), 0);

      // idle passthrough
      pipe_we    = 1'b1;
      pipe_waddr = 3'd4;
      pipe_wdata = 8'h3C;
      push(3'd4, 8'h3C, 1'b0);
      tick();
      pipe_we = 1'b0;
      chk("t3_idle_stall", 32'(pipe_stall), 0);

      // starvation with pipe_we held
      offer(3'd1, 32'hA4A3_A2A1);
      for (int k = 0; k < 4; k++) begin
         repeat (4) push(3'd7, 8'h5A, 1'b0);
         push(3'd1 + 3'(k), 8'hA1 + 8'(k), k == 3);
      end
      tick();
      mat_valid  = 1'b0;
      pipe_we    = 1'b1;
      pipe_waddr = 3'd7;
      pipe_wdata = 8'h5A;
      for (int k = 0; k < 4; k++) begin
         for (int j = 1; j <= 4; j++) begin
            tick();
            chk("t4_stall_p", 32'(pipe_stall), 32'(j == 4));
         end
         tick();
         chk("t4_stall_m", 32'(pipe_stall), 0);
      end
      pipe_we = 1'b0;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_mask", 32'(pending_mask), 0);

      // reset after byte 1
      offer(3'd0, 32'h1122_3344);
      push(3'd0, 8'h44, 1'b0);
      push(3'd1, 8'h33, 1'b0);
      tick();
      mat_valid = 1'b0;
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_we", 32'(rf_we), 0);
      chk("t5_addr", 32'(rf_waddr), 0);
      chk("t5_data", 32'(rf_wdata), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_mask", 32'(pending_mask), 0);
      chk("t5_done", 32'(mat_done), 0);
      chk("t5_stall", 32'(pipe_stall), 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("t5_ready", 32'(mat_ready), 1);
      chk("t5_busy2", 32'(busy), 0);
      tick();

      // back-to-back words with mat_valid held
      offer(3'd0, 32'h0403_0201);
      push_word(3'd0, 32'h0403_0201);
      push_word(3'd4, 32'h0807_0605);
      tick();
      mat_base = 3'd4;
      mat_data = 32'h0807_0605;
      repeat (3) begin
         tick();
         chk("t6_ready_busy", 32'(mat_ready), 0);
      end
      tick();
      chk("t6_ready", 32'(mat_ready), 1);
      tick();
      mat_valid = 1'b0;
      chk("t6_busy2", 32'(busy), 1);
      chk("t6_mask2", 32'(pending_mask), 32'hF0);
      repeat (4) tick();
      chk("t6_end", 32'(busy), 0);

      repeat (3) tick();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
